multi_press_detect: RTL
=======================

// Module: multi_press_detect
// PURPOSE
//  N-channel successor to the single-channel long-press detector. Each channel
//  synchronises and debounces a raw button input, then classifies each press.
//  Outputs: short-press pulse on release, long-press pulse at the hold
//  threshold, and optional auto-repeat pulses while the button stays held.
//  Sits between the board push-buttons and the control FSMs.
// PARAMETERS
//  N_CH           2     number of independent button channels (>=1)
//  CLK_PERIOD_ns  20    clk period; all times below are converted to cycles
//  DEBOUNCE_ns    100   DEB_CYC = DEBOUNCE_ns/CLK_PERIOD_ns; 0 = no debounce
//  PRESS_TIMER_ns 500   LONG_CYC = PRESS_TIMER_ns/CLK_PERIOD_ns; must be >=1
//  REPEAT_EN      1     1 = generate repeat pulses after long press; 0 = none
//  REPEAT_ns      200   REP_CYC = REPEAT_ns/CLK_PERIOD_ns; must be >=1
// PORTS
//  clk           in   1     system clock, all logic on rising edge
//  resetn        in   1     synchronous reset, active low
//  in            in   N_CH  raw asynchronous button levels, 1 = pressed
//  held          out  N_CH  debounced level per channel
//  short_pulse   out  N_CH  1-cycle pulse: released before long threshold
//  long_pulse    out  N_CH  1-cycle pulse: hold reached LONG_CYC
//  repeat_pulse  out  N_CH  1-cycle pulse every REP_CYC after long_pulse
// BEHAVIOUR
//  - Reset (resetn=0 at a clk edge):
//    - Sync flops, debounce counters, press counters and FSM go to 0/IDLE.
//    - All outputs go to 0. No pulse is emitted for a press cut by reset.
//    - A button still held after reset is a new press once debounced.
//  - Sync: in[i] -> 2-flop synchroniser -> s[i] (2-cycle latency).
//  - Debounce:
//    - Per-channel counter clears whenever s[i]==held[i].
//    - Otherwise it increments. held[i] toggles on the edge where the
//      counter reaches DEB_CYC; the counter clears at the same time.
//    - Glitches shorter than DEB_CYC cycles never reach held.
//    - DEB_CYC=0: held[i] = s[i] registered (1 extra cycle).
//    - Counter width = $clog2(max cycles+1); it saturates and never wraps.
//  - Per-channel FSM: IDLE, PRESS, LONG.
//    - T = first cycle with held=1.
//    - IDLE->PRESS when held rises; press counter cleared.
//    - PRESS: counter increments while held=1. At cycle T+LONG_CYC with held
//      still 1: long_pulse=1 for one cycle, go to LONG, repeat counter cleared.
//    - PRESS, held falls before then: short_pulse=1 in the first cycle
//      held=0, then IDLE.
//    - LONG with REPEAT_EN=1: repeat_pulse in cycles T+LONG_CYC+k*REP_CYC,
//      k>=1, while held=1.
//    - LONG, held falls: IDLE; no short_pulse, no further pulses.
//  - Boundaries:
//    - held falling at exactly T+LONG_CYC counts as short (held must be 1).
//    - At most one of short/long/repeat per channel per cycle.
//    - Channels are fully independent; simultaneous events on different
//      channels all pulse in the same cycle.
//    - Press counter saturates in LONG; holds of any length are safe.
// TESTING (CLK_PERIOD_ns=20, DEB 5 cyc, LONG 25 cyc, REP 10 cyc, N_CH=2)
//  1. Hold in[0]=1 for 40 cycles -> held[0] rises 7 cycles after the edge
//     (2 sync + 5 debounce); long_pulse[0] exactly 25 cycles after held
//     rises; repeat_pulse[0] at +35; no short_pulse.
//  2. in[0]=1 for 12 cycles -> one short_pulse[0] in the first held=0 cycle;
//     long_pulse[0] stays 0.
//  3. Glitches of 1-4 cycles on in[1] -> held/short/long/repeat all stay 0.
//  4. in[0] long hold and in[1] short press ending on the same cycle as
//     long_pulse[0] -> both pulses in that cycle; no cross-talk.
//  5. Reset at cycle 15 of a hold, in kept high -> outputs 0 during reset;
//     after release held rises 7 cycles later; long 25 cycles after that.
//  6. REPEAT_EN=0, 100-cycle hold -> exactly one long_pulse, zero repeats.

Source files
------------

// File: rtl/multi_press_detect.sv
// Multi-channel push-button front end: 2-flop sync, debounce, and
// short / long / auto-repeat press classification per channel.
module multi_press_detect #(
    parameter int unsigned N_CH           = 2,
    parameter int unsigned CLK_PERIOD_ns  = 20,
    parameter int unsigned DEBOUNCE_ns    = 100,
    parameter int unsigned PRESS_TIMER_ns = 500,
    parameter int unsigned REPEAT_EN      = 1,
    parameter int unsigned REPEAT_ns      = 200
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [N_CH-1:0] in,
    output logic [N_CH-1:0] held,
    output logic [N_CH-1:0] short_pulse,
    output logic [N_CH-1:0] long_pulse,
    output logic [N_CH-1:0] repeat_pulse
);

    localparam int unsigned DEB_CYC  = DEBOUNCE_ns / CLK_PERIOD_ns;
    localparam int unsigned LONG_CYC = PRESS_TIMER_ns / CLK_PERIOD_ns;
    localparam int unsigned REP_CYC  = REPEAT_ns / CLK_PERIOD_ns;
    localparam int unsigned DW = (DEB_CYC > 0) ? $clog2(DEB_CYC + 1) : 1;
    localparam int unsigned PW = $clog2(LONG_CYC + 1);
    localparam int unsigned RW = $clog2(REP_CYC + 1);

    localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYC);
    localparam logic [PW-1:0] LONG_MAX = PW'(LONG_CYC);
    localparam logic [RW-1:0] REP_MAX  = RW'(REP_CYC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        LONG  = 2'd2
    } state_t;

    logic [N_CH-1:0] sync1_q, sync1_d;
    logic [N_CH-1:0] s_q, s_d;
    logic [N_CH-1:0] held_q, held_d;
    logic [N_CH-1:0] short_pulse_q, short_pulse_d;
    logic [N_CH-1:0] long_pulse_q, long_pulse_d;
    logic [N_CH-1:0] repeat_pulse_q, repeat_pulse_d;
    logic [DW-1:0]   deb_cnt_q [N_CH];
    logic [DW-1:0]   deb_cnt_d [N_CH];
    logic [PW-1:0]   press_cnt_q [N_CH];
    logic [PW-1:0]   press_cnt_d [N_CH];
    logic [RW-1:0]   rep_cnt_q [N_CH];
    logic [RW-1:0]   rep_cnt_d [N_CH];
    state_t          state_q [N_CH];
    state_t          state_d [N_CH];

    always_comb begin
        sync1_d        = in;
        s_d            = sync1_q;
        held_d         = held_q;
        short_pulse_d  = '0;
        long_pulse_d   = '0;
        repeat_pulse_d = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            deb_cnt_d[i]   = '0;
            press_cnt_d[i] = press_cnt_q[i];
            rep_cnt_d[i]   = rep_cnt_q[i];
            state_d[i]     = state_q[i];

            if (DEB_CYC == 0) begin
                held_d[i] = s_q[i];
            end else if (s_q[i] != held_q[i]) begin
                if (deb_cnt_q[i] >= DEB_MAX - DW'(1)) begin
                    held_d[i] = ~held_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
                end
            end

            // Classification looks at the next debounced level so each pulse
            // lines up with the first cycle in which held shows the change.
            case (state_q[i])
                IDLE: begin
                    if (held_d[i]) begin
                        state_d[i]     = PRESS;
                        press_cnt_d[i] = '0;
                    end
                end
                PRESS: begin
                    if (!held_d[i]) begin
                        short_pulse_d[i] = 1'b1;
                        state_d[i]       = IDLE;
                    end else if (press_cnt_q[i] + PW'(1) == LONG_MAX) begin
                        long_pulse_d[i] = 1'b1;
                        press_cnt_d[i]  = LONG_MAX;
                        rep_cnt_d[i]    = '0;
                        state_d[i]      = LONG;
                    end else begin
                        press_cnt_d[i] = press_cnt_q[i] + PW'(1);
                    end
                end
                LONG: begin
                    if (!held_d[i]) begin
                        state_d[i] = IDLE;
                    end else if (REPEAT_EN != 0) begin
                        if (rep_cnt_q[i] + RW'(1) == REP_MAX) begin
                            repeat_pulse_d[i] = 1'b1;
                            rep_cnt_d[i]      = '0;
                        end else begin
                            rep_cnt_d[i] = rep_cnt_q[i] + RW'(1);
                        end
                    end
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_q        <= '0;
            s_q            <= '0;
            held_q         <= '0;
            short_pulse_q  <= '0;
            long_pulse_q   <= '0;
            repeat_pulse_q <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                deb_cnt_q[i]   <= '0;
                press_cnt_q[i] <= '0;
                rep_cnt_q[i]   <= '0;
                state_q[i]     <= IDLE;
            end
        end else begin
            sync1_q        <= sync1_d;
            s_q            <= s_d;
            held_q         <= held_d;
            short_pulse_q  <= short_pulse_d;
            long_pulse_q   <= long_pulse_d;
            repeat_pulse_q <= repeat_pulse_d;
            for (int unsigned i = 0; i < N_CH; i++) begin
                deb_cnt_q[i]   <= deb_cnt_d[i];
                press_cnt_q[i] <= press_cnt_d[i];
                rep_cnt_q[i]   <= rep_cnt_d[i];
                state_q[i]     <= state_d[i];
            end
        end
    end

    assign held         = held_q;
    assign short_pulse  = short_pulse_q;
    assign long_pulse   = long_pulse_q;
    assign repeat_pulse = repeat_pulse_q;

endmodule
